// File: rtl/pixel_assembler.sv
`timescale 1ns/1ps
// Assembles byte-serial R/G/B components into 24-bit pixels, inserts blank pixels,
// and tracks line/frame position. Define FRAME_CRC_EN for the per-frame checksum.
module pixel_assembler #(
  parameter int H_TOTAL = 12,
  parameter int V_TOTAL = 12
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  DataIn,
  input  logic        SelR,
  input  logic        SelG,
  input  logic        SelB,
  input  logic        SelBlank,
  input  logic        FrameStart,
  output logic [23:0] PixelOut,
  output logic        PixelValid,
  output logic        BlankOut,
  output logic        HSync,
  output logic        VSync,
  output logic        ErrSeq,
  output logic [7:0]  FrameSum
);

  typedef enum logic [1:0] {WAIT_R, HAVE_R, HAVE_G} state_t;

  state_t     state, state_next;
  logic [7:0] comp_r, comp_g;
  logic [1:0] phase, phase_next;
  logic [7:0] hcount, vcount;
  logic [1:0] nsel;
  logic       cap_r, cap_g, emit_act, emit_blank, err_set;
  logic       emit, h_wrap, v_wrap;

  always_comb begin
    state_next = state;
    phase_next = 2'd0;
    cap_r      = 1'b0;
    cap_g      = 1'b0;
    emit_act   = 1'b0;
    emit_blank = 1'b0;
    err_set    = 1'b0;
    nsel       = {1'b0, SelR} + {1'b0, SelG} + {1'b0, SelB};
    if (FrameStart) begin
      state_next = WAIT_R;
    end else if (SelBlank) begin
      state_next = WAIT_R;
      if (phase == 2'd2) emit_blank = 1'b1;
      else               phase_next = phase + 2'd1;
    end else if (nsel > 2'd1) begin
      err_set    = 1'b1;
      state_next = WAIT_R;
    end else if (SelR) begin
      // An out-of-order R restarts the pixel rather than being dropped
      err_set    = (state != WAIT_R);
      cap_r      = 1'b1;
      state_next = HAVE_R;
    end else if (SelG) begin
      if (state == HAVE_R) begin
        cap_g      = 1'b1;
        state_next = HAVE_G;
      end else begin
        err_set    = 1'b1;
        state_next = WAIT_R;
      end
    end else if (SelB) begin
      if (state == HAVE_G) emit_act = 1'b1;
      else                 err_set  = 1'b1;
      state_next = WAIT_R;
    end
  end

  assign emit   = emit_act | emit_blank;
  assign h_wrap = emit && (hcount == 8'(H_TOTAL - 1));
  assign v_wrap = h_wrap && (vcount == 8'(V_TOTAL - 1));

  always_ff @(posedge Clock) begin
    if (Reset) state <= WAIT_R;
    else       state <= state_next;
  end

  always_ff @(posedge Clock) begin
    if (cap_r) comp_r <= DataIn;
    if (cap_g) comp_g <= DataIn;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase      <= 2'd0;
      hcount     <= 8'd0;
      vcount     <= 8'd0;
      PixelOut   <= 24'd0;
      PixelValid <= 1'b0;
      BlankOut   <= 1'b0;
      HSync      <= 1'b0;
      VSync      <= 1'b0;
      ErrSeq     <= 1'b0;
    end else begin
      phase      <= phase_next;
      PixelValid <= emit;
      BlankOut   <= emit_blank;
      HSync      <= h_wrap;
      VSync      <= v_wrap;
      if (err_set) ErrSeq <= 1'b1;
      if (emit_act)        PixelOut <= {comp_r, comp_g, DataIn};
      else if (emit_blank) PixelOut <= 24'd0;
      if (FrameStart) begin
        hcount <= 8'd0;
        vcount <= 8'd0;
      end else if (emit) begin
        if (h_wrap) begin
          hcount <= 8'd0;
          vcount <= v_wrap ? 8'd0 : vcount + 8'd1;
        end else begin
          hcount <= hcount + 8'd1;
        end
      end
    end
  end

`ifdef FRAME_CRC_EN
  logic [7:0] acc, acc_next;

  always_comb begin
    acc_next = acc;
    if (emit_act) acc_next = {acc[6:0], acc[7]} ^ comp_r ^ comp_g ^ DataIn;
  end

  // The frame's last pixel is folded in before the sum is published
  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc      <= 8'd0;
      FrameSum <= 8'd0;
    end else if (FrameStart) begin
      acc <= 8'd0;
    end else if (v_wrap) begin
      FrameSum <= acc_next;
      acc      <= 8'd0;
    end else begin
      acc <= acc_next;
    end
  end
`else
  assign FrameSum = 8'd0;
`endif

endmodule

// File: tb/tb_pixel_assembler.sv
`timescale 1ns/1ps
// Directed bench for pixel_assembler: a component-list model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_pixel_assembler;
  localparam int H_TOTAL = 12;
  localparam int V_TOTAL = 12;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  DataIn = 8'h00;
  logic        SelR = 1'b0, SelG = 1'b0, SelB = 1'b0, SelBlank = 1'b0, FrameStart = 1'b0;
  logic [23:0] PixelOut;
  logic        PixelValid, BlankOut, HSync, VSync, ErrSeq;
  logic [7:0]  FrameSum;

  pixel_assembler #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) dut (
    .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .SelR(SelR), .SelG(SelG),
    .SelB(SelB), .SelBlank(SelBlank), .FrameStart(FrameStart), .PixelOut(PixelOut),
    .PixelValid(PixelValid), .BlankOut(BlankOut), .HSync(HSync), .VSync(VSync),
    .ErrSeq(ErrSeq), .FrameSum(FrameSum)
  );

  always #5 Clock = ~Clock;

  // Model: components held so far for the current pixel, position and outputs
  logic [7:0]  m_comp[$];
  int          m_h = 0, m_v = 0, m_phase = 0;
  logic [7:0]  m_acc = 8'h00;
  logic [23:0] e_pix = 24'h0;
  logic        e_vld = 1'b0, e_blank = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_err = 1'b0;
  logic [7:0]  e_sum = 8'h00;

  function automatic void m_emit(input logic [23:0] pix, input logic blank);
    e_vld   = 1'b1;
    e_blank = blank;
    e_pix   = pix;
    if (!blank) m_acc = {m_acc[6:0], m_acc[7]} ^ pix[23:16] ^ pix[15:8] ^ pix[7:0];
    if (m_h == H_TOTAL - 1) begin
      m_h  = 0;
      e_hs = 1'b1;
      if (m_v == V_TOTAL - 1) begin
        m_v  = 0;
        e_vs = 1'b1;
`ifdef FRAME_CRC_EN
        e_sum = m_acc;
`endif
        m_acc = 8'h00;
      end else begin
        m_v++;
      end
    end else begin
      m_h++;
    end
  endfunction

  always @(posedge Clock) begin : model
    int which;
    e_vld = 1'b0; e_blank = 1'b0; e_hs = 1'b0; e_vs = 1'b0;
    if (Reset) begin
      m_comp.delete();
      m_h = 0; m_v = 0; m_phase = 0; m_acc = 8'h00;
      e_pix = 24'h0; e_err = 1'b0; e_sum = 8'h00;
    end else if (FrameStart) begin
      m_comp.delete();
      m_h = 0; m_v = 0; m_phase = 0; m_acc = 8'h00;
    end else if (SelBlank) begin
      m_comp.delete();
      if (m_phase == 2) begin
        m_phase = 0;
        m_emit(24'h0, 1'b1);
      end else begin
        m_phase++;
      end
    end else begin
      m_phase = 0;
      if (int'(SelR) + int'(SelG) + int'(SelB) > 1) begin
        e_err = 1'b1;
        m_comp.delete();
      end else if (SelR | SelG | SelB) begin
        which = SelR ? 0 : (SelG ? 1 : 2);
        if (which != m_comp.size()) begin
          e_err = 1'b1;
          m_comp.delete();
        end
        if (which == m_comp.size()) begin
          m_comp.push_back(DataIn);
          if (m_comp.size() == 3) begin
            m_emit({m_comp[0], m_comp[1], m_comp[2]}, 1'b0);
            m_comp.delete();
          end
        end
      end
    end
  end

  int          checks = 0, fails = 0;
  logic        cmp_en = 1'b0;
  int          cyc_n = 0, npix = 0, nblank = 0, hs_cnt = 0, hs_last = 0, vs_pix = 0;
  int          last_t = 0, prev_t = 0;
  logic [23:0] last_pix = 24'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic g, input logic b, input logic bl,
                     input logic fs, input logic [7:0] d);
    @(posedge Clock);
    #2;
    SelR = r; SelG = g; SelB = b; SelBlank = bl; FrameStart = fs; DataIn = d;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic pix(input logic [23:0] p);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, p[23:16]);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, p[15:8]);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, p[7:0]);
  endtask

  task automatic pulse_reset(input int n);
    @(posedge Clock);
    #2;
    Reset = 1'b1; SelR = 0; SelG = 0; SelB = 0; SelBlank = 0; FrameStart = 0;
    idle(n);
    Reset = 1'b0;
  endtask

  task automatic run_tests();
    int base, bblank, bhs;
    idle(1);
    cmp_en = 1'b1;
    idle(1);
    @(negedge Clock);
    #1;
    chk("rst_PixelOut", PixelOut, 24'h0);
    chk("rst_PixelValid", PixelValid, 1'b0);
    chk("rst_ErrSeq", ErrSeq, 1'b0);
    chk("rst_FrameSum", FrameSum, 8'h00);
    Reset = 1'b0;

    // Single pixel
    base = npix; bblank = nblank;
    pix(24'h112233);
    idle(2);
    chk("t1_count", npix - base, 1);
    chk("t1_pix", last_pix, 24'h112233);
    chk("t1_blank", nblank - bblank, 0);
    chk("t1_err", ErrSeq, 1'b0);

    // Nine blank clocks with a stray SelR that must be ignored
    base = npix; bblank = nblank;
    for (int i = 0; i < 9; i++) cyc(1'(i % 2), 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
    idle(2);
    chk("t2_count", npix - base, 3);
    chk("t2_blank", nblank - bblank, 3);
    chk("t2_pix", last_pix, 24'h0);
    chk("t2_gap", last_t - prev_t, 3);
    chk("t2_err", ErrSeq, 1'b0);

    // Realign, then a full frame of 0x010203 (XOR of components is 0)
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    base = npix; bhs = hs_cnt;
    for (int i = 0; i < 12; i++) pix(24'h010203);
    idle(2);
    chk("t3_hs_once", hs_cnt - bhs, 1);
    chk("t3_hs_at12", hs_last - base, 12);
    for (int i = 12; i < 144; i++) pix(24'h010203);
    idle(2);
    chk("t3_hs_total", hs_cnt - bhs, 12);
    chk("t3_vs_at144", vs_pix - base, 144);
    chk("t3_sum", FrameSum, 8'h00);

    // Second frame: only the first pixel contributes 0x01, rotated 143 times -> 0x80
    base = npix;
    pix(24'h010000);
    for (int i = 1; i < 144; i++) pix(24'h010203);
    idle(2);
    chk("t3b_vs_at144", vs_pix - base, 144);
`ifdef FRAME_CRC_EN
    chk("t3b_sum", FrameSum, 8'h80);
`else
    chk("t3b_sum", FrameSum, 8'h00);
`endif

    // R then B skipping G, then a clean triple
    base = npix;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h66);
    idle(2);
    chk("t4_nopix", npix - base, 0);
    chk("t4_err", ErrSeq, 1'b1);
    pix(24'hAABBCC);
    idle(2);
    chk("t4_pix", last_pix, 24'hAABBCC);
    chk("t4_count", npix - base, 1);
    chk("t4_err_sticky", ErrSeq, 1'b1);

    // Reset mid-pixel discards R/G and clears ErrSeq
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h34);
    pulse_reset(2);
    idle(1);
    chk("t5_rst_err", ErrSeq, 1'b0);
    chk("t5_rst_pix", PixelOut, 24'h0);
    base = npix;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h56);
    idle(2);
    chk("t5_b_after_rst", npix - base, 0);

    // Double strobe discards the held R: following G,B must not emit
    pulse_reset(1);
    base = npix;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    idle(1);
    chk("t5_dbl_err", ErrSeq, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04);
    idle(2);
    chk("t5_dbl_nopix", npix - base, 0);

    // FrameStart with SelB in HAVE_G suppresses the pixel and realigns HCount
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h09);
    idle(2);
    chk("t5_fs_nopix", npix - base, 0);
    chk("t5_fs_err_kept", ErrSeq, 1'b1);
    for (int i = 0; i < 12; i++) pix(24'h0A0B0C);
    idle(2);
    chk("t5_fs_hs_at12", hs_last - base, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  endtask

  initial begin
    fork
      forever begin
        @(negedge Clock);
        cyc_n++;
        if (cmp_en) begin
          chk("PixelValid", PixelValid, e_vld);
          chk("PixelOut", PixelOut, e_pix);
          if (e_vld) chk("BlankOut", BlankOut, e_blank);
          chk("HSync", HSync, e_hs);
          chk("VSync", VSync, e_vs);
          chk("ErrSeq", ErrSeq, e_err);
          chk("FrameSum", FrameSum, e_sum);
          if (PixelValid) begin
            npix++;
            prev_t   = last_t;
            last_t   = cyc_n;
            last_pix = PixelOut;
            if (BlankOut) nblank++;
            if (HSync) begin
              hs_cnt++;
              hs_last = npix;
            end
            if (VSync) vs_pix = npix;
          end
        end
      end
      run_tests();
    join_any
  end

endmodule
